// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use and multi-cycle EX stalls,
// wrong-path squash behind decode-resolved branches, stall-cycle counter.
module pipe_ctrl #(
  parameter int unsigned MULTI_CYCLES = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_reg1_read,
  input  logic             id_reg2_read,
  input  logic [4:0]       id_reg1_addr,
  input  logic [4:0]       id_reg2_addr,
  input  logic             id_branch_flag,
  input  logic             ex_wreg,
  input  logic [4:0]       ex_wd,
  input  logic             ex_is_load,
  input  logic             ex_multi,
  output logic [5:0]       stall,
  output logic             flush_id,
  output logic             ex_busy,
  output logic             ex_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] CNT_LOAD = 4'(MULTI_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       busy_q;
  logic       done_q;
  logic       flush_q;
  logic       lu_req;
  logic       mc_req;
  logic       id_hit;

  // Hazard requests; a squashed ID instruction cannot cause a load-use stall
  always_comb begin
    id_hit = (id_reg1_read && (id_reg1_addr == ex_wd)) ||
             (id_reg2_read && (id_reg2_addr == ex_wd));
    lu_req = ex_is_load && ex_wreg && (ex_wd != 5'd0) && id_hit && !flush_q;
    mc_req = ((state == IDLE) && ex_multi) || (state == BUSY);
  end

  // Stall vector; multi-cycle stall dominates and holds EX as well
  always_comb begin
    stall = 6'b000000;
    if (!rst) begin
      if (mc_req) begin
        stall = 6'b001111;
      end else if (lu_req) begin
        stall = 6'b000111;
      end
    end
  end

  // Multi-cycle EX sequencer; DONE ignores ex_multi since the op is still in EX
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_multi) begin
            state  <= BUSY;
            cnt    <= CNT_LOAD;
            busy_q <= 1'b1;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // One-cycle squash pulse once a taken branch actually advances out of ID
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_q <= 1'b0;
    end else begin
      flush_q <= id_branch_flag && !stall[2] && !flush_q;
    end
  end

  // Saturating count of cycles in which the PC is held
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall[0] && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign flush_id = flush_q;
  assign ex_busy  = busy_q;
  assign ex_done  = done_q && !rst;

endmodule
